// File: rtl/led_status.sv
// Board user LED driver: boot, USB-disconnected blink, idle, activity off-flash
// and PWM breathing while the application sleeps.
module led_status #(
    parameter int BOOT_CYCLES  = 1048576,
    parameter int DISC_HALF    = 250000,
    parameter int FLASH_CYCLES = 50000,
    parameter int PWM_BITS     = 8,
    parameter int BREATH_STEP  = 2048
) (
    input  logic       clk_1mhz,
    input  logic       rstn,
    input  logic       dp_pu_i,
    input  logic       sleep_i,
    input  logic       act_tgl_i,
    output logic       led_o,
    output logic [2:0] state_o
);

    localparam int TMR_MAX_BD = (BOOT_CYCLES > DISC_HALF) ? BOOT_CYCLES : DISC_HALF;
    localparam int TMR_MAX    = (TMR_MAX_BD > FLASH_CYCLES) ? TMR_MAX_BD : FLASH_CYCLES;
    localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int STEP_W     = (BREATH_STEP > 1) ? $clog2(BREATH_STEP) : 1;

    localparam logic [TMR_W-1:0]    BOOT_LAST  = TMR_W'(BOOT_CYCLES - 1);
    localparam logic [TMR_W-1:0]    DISC_LAST  = TMR_W'(DISC_HALF - 1);
    localparam logic [TMR_W-1:0]    FLASH_LAST = TMR_W'(FLASH_CYCLES - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(BREATH_STEP - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
    localparam logic [PWM_BITS-1:0] DUTY_TOP   = DUTY_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        DISC  = 3'd1,
        IDLE  = 3'd2,
        FLASH = 3'd3,
        SLEEP = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TMR_W-1:0]    tmr;
    logic [TMR_W-1:0]    tmr_next;
    logic                dp_pu_meta, dp_pu_s;
    logic                sleep_meta, sleep_s;
    logic                act_meta, act_s, act_d;
    logic                act_p;
    logic                blink;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                dir_up;
    logic [STEP_W-1:0]   step_cnt;

    // All three inputs come from foreign clock domains.
    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            dp_pu_meta <= 1'b0;
            dp_pu_s    <= 1'b0;
            sleep_meta <= 1'b0;
            sleep_s    <= 1'b0;
            act_meta   <= 1'b0;
            act_s      <= 1'b0;
            act_d      <= 1'b0;
        end else begin
            dp_pu_meta <= dp_pu_i;
            dp_pu_s    <= dp_pu_meta;
            sleep_meta <= sleep_i;
            sleep_s    <= sleep_meta;
            act_meta   <= act_tgl_i;
            act_s      <= act_meta;
            act_d      <= act_s;
        end
    end

    assign act_p = act_s ^ act_d;

    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            state <= BOOT;
            tmr   <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

    // Loss of the USB pull-up beats activity, which beats sleep changes.
    always_comb begin
        state_next = state;
        tmr_next   = tmr + 1'b1;
        case (state)
            BOOT: begin
                if (tmr == BOOT_LAST)
                    state_next = dp_pu_s ? IDLE : DISC;
            end
            DISC: begin
                if (dp_pu_s)
                    state_next = IDLE;
                else if (tmr == DISC_LAST)
                    tmr_next = '0;
            end
            IDLE: begin
                tmr_next = '0;
                if (!dp_pu_s)
                    state_next = DISC;
                else if (act_p)
                    state_next = FLASH;
                else if (sleep_s)
                    state_next = SLEEP;
            end
            FLASH: begin
                if (!dp_pu_s)
                    state_next = DISC;
                else if (act_p)
                    tmr_next = '0;
                else if (tmr == FLASH_LAST)
                    state_next = IDLE;
            end
            SLEEP: begin
                tmr_next = '0;
                if (!dp_pu_s)
                    state_next = DISC;
                else if (act_p)
                    state_next = FLASH;
                else if (!sleep_s)
                    state_next = IDLE;
            end
            default: state_next = BOOT;
        endcase
        if (state_next != state)
            tmr_next = '0;
    end

    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn)
            blink <= 1'b0;
        else if (state_next == DISC && state != DISC)
            blink <= 1'b1;
        else if (state == DISC && tmr == DISC_LAST)
            blink <= ~blink;
    end

    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Duty ramps up to full and back down without ever wrapping.
    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            duty     <= '0;
            dir_up   <= 1'b1;
            step_cnt <= '0;
        end else if (state_next == SLEEP && state != SLEEP) begin
            duty     <= '0;
            dir_up   <= 1'b1;
            step_cnt <= '0;
        end else if (state == SLEEP) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (dir_up) begin
                    duty <= duty + 1'b1;
                    if (duty == DUTY_TOP)
                        dir_up <= 1'b0;
                end else begin
                    duty <= duty - 1'b1;
                    if (duty == DUTY_ONE)
                        dir_up <= 1'b1;
                end
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1mhz or negedge rstn) begin
        if (!rstn) begin
            led_o <= 1'b1;
        end else begin
            case (state)
                BOOT, IDLE: led_o <= 1'b1;
                DISC:       led_o <= blink;
                FLASH:      led_o <= 1'b0;
                SLEEP:      led_o <= (pwm_cnt < duty);
                default:    led_o <= 1'b1;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_led_status.sv
// Scoreboard bench for led_status: expectations are queued with a due cycle when
// stimulus is applied and compared when that cycle's outputs settle.
module tb_led_status;

    logic       clk_1mhz;
    logic       rstn;
    logic       dp_pu_i;
    logic       sleep_i;
    logic       act_tgl_i;
    logic       led_o;
    logic [2:0] state_o;

    typedef struct {
        int         due;
        string      tag;
        bit         is_led;
        logic [7:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       cyc = 0;
    int       rel_cyc = 0;
    int       checks = 0;
    int       errors = 0;

    led_status #(
        .BOOT_CYCLES (16),
        .DISC_HALF   (4),
        .FLASH_CYCLES(8),
        .PWM_BITS    (4),
        .BREATH_STEP (2)
    ) dut (
        .clk_1mhz (clk_1mhz),
        .rstn     (rstn),
        .dp_pu_i  (dp_pu_i),
        .sleep_i  (sleep_i),
        .act_tgl_i(act_tgl_i),
        .led_o    (led_o),
        .state_o  (state_o)
    );

    initial begin
        clk_1mhz = 1'b0;
        forever #5 clk_1mhz = ~clk_1mhz;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic dp, input logic slp, input logic tgl);
        rstn    = rst_n;
        dp_pu_i = dp;
        sleep_i = slp;
        if (tgl)
            act_tgl_i = ~act_tgl_i;
    endtask

    task automatic pushExp(input int off, input string tag, input bit is_led, input logic [7:0] val);
        sb_item_t it;
        it.due    = cyc + off;
        it.tag    = tag;
        it.is_led = is_led;
        it.exp    = val;
        sb.push_back(it);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_1mhz);
    endtask

    function automatic int dutyAt(input int j);
        if (j <= 30)
            return j / 2;
        return 15 - (j - 30) / 2;
    endfunction

    // Outputs are compared 1 time unit after each rising edge.
    always @(posedge clk_1mhz) begin
        #1;
        cyc = cyc + 1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                if (sb[i].is_led)
                    checkOutput(sb[i].tag, {7'd0, led_o}, sb[i].exp);
                else
                    checkOutput(sb[i].tag, {5'd0, state_o}, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        int base;
        rstn      = 1'b0;
        dp_pu_i   = 1'b0;
        sleep_i   = 1'b0;
        act_tgl_i = 1'b0;
        waitCycles(3);
        checkOutput("rst_led", {7'd0, led_o}, 8'd1);
        checkOutput("rst_state", {5'd0, state_o}, 8'd0);

        $display("[TB] boot with USB disconnected");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        rel_cyc = cyc;
        for (int k = 1; k <= 15; k++) pushExp(k, "boot_state", 1'b0, 8'd0);
        for (int k = 1; k <= 16; k++) pushExp(k, "boot_led", 1'b1, 8'd1);
        for (int k = 16; k <= 32; k++) pushExp(k, "disc_state", 1'b0, 8'd1);
        for (int k = 17; k <= 32; k++)
            pushExp(k, "disc_blink", 1'b1, (((k - 17) / 4) % 2 == 0) ? 8'd1 : 8'd0);
        waitCycles(34);

        $display("[TB] boot with USB connected, then disconnect");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        rel_cyc = cyc;
        for (int k = 1; k <= 15; k++) pushExp(k, "boot2_state", 1'b0, 8'd0);
        for (int k = 16; k <= 20; k++) pushExp(k, "idle_state", 1'b0, 8'd2);
        for (int k = 1; k <= 20; k++) pushExp(k, "boot2_led", 1'b1, 8'd1);
        waitCycles(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        pushExp(1, "drop_hold", 1'b0, 8'd2);
        pushExp(2, "drop_hold", 1'b0, 8'd2);
        pushExp(3, "drop_disc", 1'b0, 8'd1);
        for (int k = 4; k <= 7; k++) pushExp(k, "drop_led_hi", 1'b1, 8'd1);
        pushExp(8, "drop_led_lo", 1'b1, 8'd0);
        waitCycles(10);

        $display("[TB] reconnect and single activity flash");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        pushExp(1, "recon_hold", 1'b0, 8'd1);
        pushExp(2, "recon_hold", 1'b0, 8'd1);
        for (int k = 3; k <= 6; k++) pushExp(k, "recon_idle", 1'b0, 8'd2);
        pushExp(4, "recon_led", 1'b1, 8'd1);
        waitCycles(6);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        pushExp(1, "fl_pre", 1'b0, 8'd2);
        pushExp(2, "fl_pre", 1'b0, 8'd2);
        for (int k = 3; k <= 10; k++) pushExp(k, "fl_state", 1'b0, 8'd3);
        pushExp(11, "fl_back", 1'b0, 8'd2);
        for (int k = 1; k <= 3; k++) pushExp(k, "fl_led_pre", 1'b1, 8'd1);
        for (int k = 4; k <= 11; k++) pushExp(k, "fl_led_off", 1'b1, 8'd0);
        pushExp(12, "fl_led_on", 1'b1, 8'd1);
        pushExp(13, "fl_led_on", 1'b1, 8'd1);
        waitCycles(14);

        $display("[TB] extended flash");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 3; k <= 15; k++) pushExp(k, "ext_state", 1'b0, 8'd3);
        pushExp(16, "ext_back", 1'b0, 8'd2);
        for (int k = 4; k <= 16; k++) pushExp(k, "ext_led_off", 1'b1, 8'd0);
        pushExp(17, "ext_led_on", 1'b1, 8'd1);
        pushExp(18, "ext_led_on", 1'b1, 8'd1);
        waitCycles(5);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        waitCycles(15);

        $display("[TB] sleep breathing");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        base = cyc + 3;
        for (int k = 3; k <= 45; k++) pushExp(k, "slp_state", 1'b0, 8'd4);
        for (int j = 1; j <= 43; j++)
            pushExp(3 + j, "slp_pwm", 1'b1,
                    (((base + j - 1 - rel_cyc) % 16) < dutyAt(j - 1)) ? 8'd1 : 8'd0);
        pushExp(46, "wake_idle", 1'b0, 8'd2);
        pushExp(47, "wake_led", 1'b1, 8'd1);
        waitCycles(43);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        waitCycles(6);

        $display("[TB] disconnect and activity together in sleep");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        pushExp(3, "slp2_state", 1'b0, 8'd4);
        waitCycles(5);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        pushExp(1, "race_hold", 1'b0, 8'd4);
        pushExp(2, "race_hold", 1'b0, 8'd4);
        for (int k = 3; k <= 5; k++) pushExp(k, "race_disc", 1'b0, 8'd1);
        pushExp(4, "race_led", 1'b1, 8'd1);
        waitCycles(6);

        $display("[TB] reset during flash");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 3; k <= 8; k++) pushExp(k, "pre_idle", 1'b0, 8'd2);
        waitCycles(8);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 3; k <= 6; k++) pushExp(k, "mid_flash", 1'b0, 8'd3);
        for (int k = 4; k <= 6; k++) pushExp(k, "mid_flash_led", 1'b1, 8'd0);
        waitCycles(6);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_led", {7'd0, led_o}, 8'd1);
        checkOutput("async_rst_state", {5'd0, state_o}, 8'd0);
        @(negedge clk_1mhz);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        rel_cyc = cyc;
        for (int k = 1; k <= 15; k++) pushExp(k, "reboot_state", 1'b0, 8'd0);
        for (int k = 16; k <= 18; k++) pushExp(k, "reboot_idle", 1'b0, 8'd2);
        for (int k = 1; k <= 18; k++) pushExp(k, "reboot_led", 1'b1, 8'd1);
        waitCycles(20);

        for (int n = 0; n < 100 && sb.size() > 0; n++)
            @(negedge clk_1mhz);
        checkOutput("sb_drain", 8'(sb.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
